// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register word offsets and
// edge-capture selectors.
package gpio_pkg;

    localparam logic [2:0] GPIO_DATA   = 3'd0;
    localparam logic [2:0] GPIO_DIR    = 3'd1;
    localparam logic [2:0] GPIO_MASK   = 3'd2;
    localparam logic [2:0] GPIO_EDGE   = 3'd3;
    localparam logic [2:0] GPIO_OUTSET = 3'd4;
    localparam logic [2:0] GPIO_OUTCLR = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage : gpio_pkg

// File: rtl/gpio_sync_edge.sv
// Pad-input synchroniser chain followed by a one-cycle history flop and
// the selected edge detector.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] det_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise   = sync_o & ~prev_q;
    assign fall   = ~sync_o & prev_q;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: det_o = fall;
            EDGE_ANY:  det_o = rise | fall;
            default:   det_o = rise;
        endcase
    end

endmodule : gpio_sync_edge

// File: rtl/gpio_ctrl.sv
// Avalon-MM GPIO controller: data/direction/mask registers, atomic set and
// clear, W1C edge capture and a maskable level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_val;
    logic             unused_wd;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q,      dir_d;
    logic [WIDTH-1:0] mask_q,     mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (pin_in),
        .sync_o  (sync_in),
        .det_o   (det)
    );

    // NOTE: every variable written below gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        clr        = '0;
        if (wr_en) begin
            case (address)
                GPIO_DATA:   data_out_d = wd;
                GPIO_DIR:    dir_d      = wd;
                GPIO_MASK:   mask_d     = wd;
                GPIO_EDGE:   clr        = wd;
                GPIO_OUTSET: data_out_d = data_out_q | wd;
                GPIO_OUTCLR: data_out_d = data_out_q & ~wd;
                default:     ;
            endcase
        end
        // A detection coinciding with its own clear wins, so no edge is lost.
        edge_cap_d = (edge_cap_q & ~clr) | det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_OUT;
            dir_q      <= '0;
            mask_q     <= '0;
            edge_cap_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    always_comb begin
        rd_val = '0;
        if (chipselect) begin
            case (address)
                GPIO_DATA: rd_val = (dir_q & data_out_q) | (~dir_q & sync_in);
                GPIO_DIR:  rd_val = dir_q;
                GPIO_MASK: rd_val = mask_q;
                GPIO_EDGE: rd_val = edge_cap_q;
                default:   rd_val = '0;
            endcase
        end
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign irq      = |(edge_cap_q & mask_q);

endmodule : gpio_ctrl
